// File: rtl/tea_cipher_core.sv
// tea_cipher_core: iterative TEA block cipher, 64-bit block, 128-bit key.
// Each RUN clock applies UNROLL chained TEA cycles; ROUNDS cycles per block.
// Optional feature macro: TEA_CORE_DECRYPT_EN builds the decrypt datapath and
// honours in_mode. When it is undefined, every block is encrypted.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// RUN   | applying UNROLL cycles per clock until ROUNDS are done
// DONE  | result on out_data, held until out_ready
module tea_cipher_core #(
    parameter int          ROUNDS = 32,
    parameter int          UNROLL = 1,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] key,
    input  logic [63:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    localparam int STEPS = ROUNDS / UNROLL;
    localparam int CW    = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_q;
    logic [31:0]    v0_q, v1_q, sum_q;
    logic [31:0]    v0_n, v1_n, sum_n;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    k0, k1, k2, k3;
    logic           last_step;

`ifdef TEA_CORE_DECRYPT_EN
    localparam logic [63:0] SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0] SUM_DEC  = SUM_PROD[31:0];
    logic mode_q;
`else
    logic unused_mode;
    assign unused_mode = in_mode;
`endif

    function automatic logic [31:0] tea_f(input logic [31:0] v, input logic [31:0] kl,
                                          input logic [31:0] kr, input logic [31:0] s);
        return ((v << 4) + kl) ^ (v + s) ^ ((v >> 5) + kr);
    endfunction

    assign k0 = key_q[31:0];
    assign k1 = key_q[63:32];
    assign k2 = key_q[95:64];
    assign k3 = key_q[127:96];

    assign last_step = (cnt_q == CW'(STEPS - 1));

    // UNROLL chained TEA cycles computed from the current block state
    always_comb begin
        v0_n  = v0_q;
        v1_n  = v1_q;
        sum_n = sum_q;
        for (int i = 0; i < UNROLL; i++) begin
`ifdef TEA_CORE_DECRYPT_EN
            if (mode_q) begin
                v1_n  = v1_n - tea_f(v0_n, k2, k3, sum_n);
                v0_n  = v0_n - tea_f(v1_n, k0, k1, sum_n);
                sum_n = sum_n - DELTA;
            end else begin
`else
            begin
`endif
                sum_n = sum_n + DELTA;
                v0_n  = v0_n + tea_f(v1_n, k0, k1, sum_n);
                v1_n  = v1_n + tea_f(v0_n, k2, k3, sum_n);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Block datapath: latch on accept, iterate in RUN, hold in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
            v0_q  <= '0;
            v1_q  <= '0;
            sum_q <= '0;
            cnt_q <= '0;
`ifdef TEA_CORE_DECRYPT_EN
            mode_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        key_q <= key;
                        v0_q  <= in_data[31:0];
                        v1_q  <= in_data[63:32];
                        cnt_q <= '0;
`ifdef TEA_CORE_DECRYPT_EN
                        mode_q <= in_mode;
                        sum_q  <= in_mode ? SUM_DEC : 32'h0;
`else
                        sum_q  <= 32'h0;
`endif
                    end
                end
                RUN: begin
                    v0_q  <= v0_n;
                    v1_q  <= v1_n;
                    sum_q <= sum_n;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result is only visible in DONE so partial state never leaks out
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = (state_q == DONE) ? {v1_q, v0_q} : 64'h0;

endmodule

// File: tb/tb_tea_cipher_core.sv
// Directed bench for tea_cipher_core: default core (UNROLL=1) and an UNROLL=4 core.
module tb_tea_cipher_core;

    localparam logic [63:0] ZERO_CT = 64'h94BAA940_41EA3A0A;
    localparam logic [31:0] TB_DELTA = 32'h9E3779B9;

    logic         clk;
    logic         rst_n;
    logic         in_mode;
    logic [127:0] key;
    logic [63:0]  in_data;

    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0]  out_data;
    logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [63:0]  out_data4;

    int n_vec = 0;
    int n_err = 0;

    tea_cipher_core dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .key(key), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    tea_cipher_core #(.ROUNDS(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_mode(in_mode), .key(key), .in_data(in_data), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_data(out_data4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Plain C-style TEA reference
    function automatic logic [63:0] tea_ref(input logic [127:0] k, input logic [63:0] d,
                                            input bit dec, input int rounds);
        logic [31:0] v0, v1, s, a, b, c, e;
        v0 = d[31:0];
        v1 = d[63:32];
        a = k[31:0]; b = k[63:32]; c = k[95:64]; e = k[127:96];
        s = 32'h0;
        if (dec) for (int i = 0; i < rounds; i++) s = s + TB_DELTA;
        for (int i = 0; i < rounds; i++) begin
            if (!dec) begin
                s  = s + TB_DELTA;
                v0 = v0 + (((v1 << 4) + a) ^ (v1 + s) ^ ((v1 >> 5) + b));
                v1 = v1 + (((v0 << 4) + c) ^ (v0 + s) ^ ((v0 >> 5) + e));
            end else begin
                v1 = v1 - (((v0 << 4) + c) ^ (v0 + s) ^ ((v0 >> 5) + e));
                v0 = v0 - (((v1 << 4) + a) ^ (v1 + s) ^ ((v1 >> 5) + b));
                s  = s - TB_DELTA;
            end
        end
        return {v1, v0};
    endfunction

    task automatic run_block(input bit use4, input bit mode, input logic [127:0] k,
                             input logic [63:0] d, input int exp_lat,
                             input logic [63:0] exp, input bit rdy_early, input string tag);
        int lat;
        @(negedge clk);
        key = k; in_data = d; in_mode = mode;
        if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
        if (rdy_early) begin
            if (use4) out_ready4 = 1'b1; else out_ready = 1'b1;
        end
        check({tag, "_in_ready_idle"}, 64'(use4 ? in_ready4 : in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_valid4 = 1'b0;
        key = ~k; in_data = ~d; in_mode = ~mode;
        check({tag, "_busy_run"}, 64'(use4 ? busy4 : busy), 64'd1);
        check({tag, "_in_ready_run"}, 64'(use4 ? in_ready4 : in_ready), 64'd0);
        lat = 0;
        while (!(use4 ? out_valid4 : out_valid) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, use4 ? out_data4 : out_data, exp);
        @(negedge clk);
        if (use4) out_ready4 = 1'b1; else out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0; out_ready4 = 1'b0;
        check({tag, "_released"}, 64'(use4 ? out_valid4 : out_valid), 64'd0);
        check({tag, "_back_idle"}, 64'(use4 ? in_ready4 : in_ready), 64'd1);
    endtask

    logic [127:0] k_a;
    logic [63:0]  d_a, ct_a, held;
    int           lat;

    initial begin
        k_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        d_a = 64'hDEAD_BEEF_0123_4567;
        ct_a = tea_ref(k_a, d_a, 1'b0, 32);

        rst_n = 1'b0;
        in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0; out_ready4 = 1'b0;
        in_mode = 1'b0; key = '0; in_data = '0;
        #23;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", out_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_block(1'b0, 1'b0, 128'h0, 64'h0, 32, ZERO_CT, 1'b0, "enc_zero_u1");
        run_block(1'b1, 1'b0, 128'h0, 64'h0, 8, ZERO_CT, 1'b0, "enc_zero_u4");
        run_block(1'b0, 1'b0, k_a, d_a, 32, ct_a, 1'b1, "enc_a_u1_rdy_early");
        run_block(1'b1, 1'b0, k_a, d_a, 8, ct_a, 1'b0, "enc_a_u4");

`ifdef TEA_CORE_DECRYPT_EN
        run_block(1'b0, 1'b1, 128'h0, ZERO_CT, 32, 64'h0, 1'b0, "dec_zero_u1");
        run_block(1'b0, 1'b1, k_a, ct_a, 32, d_a, 1'b0, "dec_a_u1");
        run_block(1'b1, 1'b1, k_a, ct_a, 8, d_a, 1'b0, "dec_a_u4");
`else
        run_block(1'b0, 1'b1, 128'h0, 64'h0, 32, ZERO_CT, 1'b0, "mode_ignored_u1");
        run_block(1'b1, 1'b1, k_a, d_a, 8, ct_a, 1'b0, "mode_ignored_u4");
`endif

        // DONE held with out_ready low; in_valid pulses must not be taken
        @(negedge clk);
        key = k_a; in_data = d_a; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold_latency", 64'(lat), 64'd32);
        held = out_data;
        check("hold_first_data", held, ct_a);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            key = ~key; in_data = ~in_data;
            @(posedge clk);
            #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_data", out_data, held);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_release_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("hold_no_accept_busy", 64'(busy), 64'd0);

        // Reset during RUN cycle 5
        @(negedge clk);
        key = k_a; in_data = d_a; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", out_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_idle", 64'(busy), 64'd0);
        run_block(1'b0, 1'b0, 128'h0, 64'h0, 32, ZERO_CT, 1'b0, "postrst_enc_zero");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
